pcnn_pool: RTL and testbench
============================

PCNN_POOL -- requirements
Module: pcnn_pool

Interface
REQ-001 The block SHALL have parameter o_size, default 4, giving the conv output map edge length; it SHALL be even and >= 2.
REQ-002 The block SHALL have parameter shift, default 4, giving the requantization right-shift amount, range 0..11.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  start-of-frame request; sampled only in IDLE.
REQ-006 in_data  input  20  conv result sample, signed two's complement, raster order (row-major).
REQ-007 in_valid  input  1  in_data is valid this cycle; one sample is consumed per asserted cycle in RUN.
REQ-008 out_data  output  8  pooled, rectified, requantized value, unsigned.
REQ-009 out_valid  output  1  out_data is valid this cycle (one-cycle pulse per pooled value).
REQ-010 done  output  1  one-cycle pulse marking the end of the frame.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE.
- IDLE -> RUN on go=1.
- RUN -> DONE in the cycle after the o_size*o_size-th accepted sample.
- DONE -> IDLE unconditionally after one cycle.
REQ-012 In IDLE and DONE, in_valid SHALL be ignored; a sample presented in the same cycle as go in IDLE SHALL be dropped.
REQ-013 go asserted in RUN or DONE SHALL be ignored.
REQ-014 Each accepted sample SHALL be rectified and quantized as follows:
- in_data[19]=1 -> q=0.
- Otherwise v = in_data >> shift (logical); q = 255 if v > 255, else v[7:0].
REQ-015 Counters row and col SHALL track position in the o_size x o_size map.
- col wraps o_size-1 -> 0 and increments row on the wrap.
- Both counters SHALL be cleared on entry to RUN.
REQ-016 Line buffer of o_size/2 entries, 8 bits each, plus one 8-bit temp register; processing per accepted sample:
- Even row, even col: temp = q.
- Even row, odd col: linebuf[col/2] = max(temp, q).
- Odd row, even col: temp = max(linebuf[col/2], q).
- Odd row, odd col: out_data = max(temp, q), with out_valid=1 on the next clock edge.
REQ-017 Latency SHALL be 1 cycle from the bottom-right sample of a 2x2 window to out_valid.
REQ-018 Outputs SHALL appear in raster order of the (o_size/2)^2 pooled map.
REQ-019 Gaps in in_valid SHALL stall processing with no state change; output values SHALL be independent of gap pattern.
REQ-020 out_data SHALL hold its last value while out_valid=0.
REQ-021 done SHALL assert for exactly one cycle (the DONE state), one cycle after the final out_valid pulse.
REQ-022 Max comparisons SHALL be unsigned on the 8-bit quantized values.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force the following values:
- State SHALL be IDLE.
- row, col, temp and all linebuf entries SHALL be 0.
- out_data SHALL be 8'h00.
- out_valid and done SHALL be 0.
REQ-024 Reset asserted mid-frame SHALL abandon the frame: no further out_valid or done pulses, and a new frame requires go.
REQ-025 A non-even or zero o_size SHALL be flagged by a simulation-time error.

Verification (o_size=4, shift=4)
REQ-026 Ramp: go, then 16 consecutive samples k*16 (k=0..15) -> out_data 5, 7, 13, 15, each on the cycle after samples k=5, 7, 13, 15; done one cycle after the last.
REQ-027 All negative (20'hFFF00 x16) -> four out_valid pulses, each out_data=0.
REQ-028 Saturation: sample 0 = 20'h7FFFF, rest 0 -> first output 255, others 0.
REQ-029 Ramp of REQ-026 with in_valid low for 3 cycles after every sample -> same four values in the same order; done one cycle after the last out_valid.
REQ-030 Reset pulse after 9 samples, then go plus a full ramp -> no outputs before the reset-recovery go, then exactly 5, 7, 13, 15; go pulses during RUN have no effect.
REQ-031 Samples with in_valid=1 in IDLE (no go) -> no out_valid and no done.

Source files
------------

// File: rtl/pcnn_pool.sv
// 2x2 max-pool stage for a conv output map: rectify, requantize to 8 bits,
// then pool a raster-order stream of o_size x o_size samples.
module pcnn_pool #(
  parameter int o_size = 4,
  parameter int shift  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [19:0] in_data,
  input  logic        in_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        done
);

  localparam int half = o_size / 2;
  localparam int cw   = (o_size > 2) ? $clog2(o_size) : 1;
  localparam int lw   = (half > 1) ? $clog2(half) : 1;

  if ((o_size < 2) || (o_size % 2 != 0)) begin : g_bad_size
    $error("pcnn_pool: o_size must be even and >= 2 (got %0d)", o_size);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [cw-1:0]  row;
  logic [cw-1:0]  col;
  logic [7:0]     temp;
  logic [7:0]     linebuf [half];

  logic [19:0]    v;
  logic [7:0]     q;
  logic [lw-1:0]  idx;
  logic           last;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    v    = in_data >> shift;
    q    = 8'd0;
    if (!in_data[19])
      q = (v > 20'd255) ? 8'd255 : v[7:0];
    idx  = lw'(col >> 1);
    last = (row == cw'(o_size - 1)) && (col == cw'(o_size - 1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      temp      <= 8'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      done      <= 1'b0;
      // NOTE: the line buffer is small and must come up zeroed, so it is
      // built from resettable flops rather than a RAM macro.
      for (int i = 0; i < half; i++) linebuf[i] <= 8'd0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state <= RUN;
            row   <= '0;
            col   <= '0;
          end
        end
        RUN: begin
          if (in_valid) begin
            unique case ({row[0], col[0]})
              2'b00: temp         <= q;
              2'b01: linebuf[idx] <= max8(temp, q);
              2'b10: temp         <= max8(linebuf[idx], q);
              2'b11: begin
                out_data  <= max8(temp, q);
                out_valid <= 1'b1;
              end
            endcase
            if (last) begin
              row   <= '0;
              col   <= '0;
              state <= DONE;
            end else if (col == cw'(o_size - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DONE: begin
          // done is registered, so it lands one cycle after the final pooled value
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcnn_pool.sv
// Self-checking bench for pcnn_pool (o_size=4, shift=4): directed frames plus
// randomized frames compared against a behavioural pooling model.
module tb_pcnn_pool;

  localparam int N = 4;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [19:0] in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [19:0] frame [N*N];

  pcnn_pool #(.o_size(N), .shift(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Rectify then requantize, straight from the arithmetic definition.
  function automatic int quant(input logic [19:0] s);
    int val;
    if (s[19]) return 0;
    val = int'(s) / (1 << S);
    return (val > 255) ? 255 : val;
  endfunction

  // Pooled value of window w (raster order over the (N/2)x(N/2) map).
  function automatic int pool_ref(input int w);
    int best = 0;
    int r0 = (w / (N/2)) * 2;
    int c0 = (w % (N/2)) * 2;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (quant(frame[(r0+dr)*N + c0+dc]) > best) best = quant(frame[(r0+dr)*N + c0+dc]);
    return best;
  endfunction

  // Drives the first n samples of frame[] after a go; gap idle cycles follow
  // each sample except the last. go_in_run keeps go high throughout RUN.
  task automatic drive_frame(input int n, input int gap, input bit go_in_run);
    int  exp_q[$];
    int  last_out = 0;
    bit  have_out = 0;
    bit  br;
    for (int w = 0; w < (N/2)*(N/2); w++) exp_q.push_back(pool_ref(w));
    go = 1'b1; in_valid = 1'b1; in_data = 20'h7FFFF;  // must be dropped
    step();
    go = 1'b0; in_valid = 1'b0;
    check("go_cycle_no_out", {31'd0, out_valid}, 0);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_data = frame[k]; go = go_in_run;
      step();
      in_valid = 1'b0; go = 1'b0;
      br = ((k / N) % 2 == 1) && ((k % N) % 2 == 1);
      check($sformatf("valid_k%0d", k), {31'd0, out_valid}, {31'd0, br});
      check($sformatf("done_early_k%0d", k), {31'd0, done}, 0);
      if (br) begin
        last_out = exp_q.pop_front();
        have_out = 1;
        check($sformatf("data_k%0d", k), {24'd0, out_data}, last_out);
      end
      if (k != N*N-1) begin
        for (int g = 0; g < gap; g++) begin
          in_data = 20'($urandom); go = go_in_run;
          step();
          go = 1'b0;
          check("gap_no_valid", {31'd0, out_valid}, 0);
          if (have_out) check("gap_hold", {24'd0, out_data}, last_out);
        end
      end
    end
    if (n == N*N) begin
      step();
      check("done_pulse", {31'd0, done}, 1);
      check("done_no_valid", {31'd0, out_valid}, 0);
      step();
      check("done_one_cycle", {31'd0, done}, 0);
    end
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = 20'd0;
    #12;
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Ramp: k*16 quantizes to k, so pooled values are 5, 7, 13, 15.
    for (int k = 0; k < N*N; k++) frame[k] = 20'(k * 16);
    drive_frame(N*N, 0, 0);

    // All negative samples rectify to zero.
    for (int k = 0; k < N*N; k++) frame[k] = 20'hFFF00;
    drive_frame(N*N, 0, 0);

    // Saturation of the first sample only.
    for (int k = 0; k < N*N; k++) frame[k] = 20'd0;
    frame[0] = 20'h7FFFF;
    drive_frame(N*N, 0, 0);

    // Ramp with three idle cycles after each sample.
    for (int k = 0; k < N*N; k++) frame[k] = 20'(k * 16);
    drive_frame(N*N, 3, 0);

    // Reset mid-frame after nine samples, then idle traffic, then a clean ramp.
    drive_frame(9, 0, 0);
    reset = 1'b0;
    #2;
    check("midrst_out_data", {24'd0, out_data}, 0);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_data = 20'(c * 16);
      step();
      check("abandoned_no_valid", {31'd0, out_valid}, 0);
      check("abandoned_no_done", {31'd0, done}, 0);
    end
    in_valid = 1'b0;
    drive_frame(N*N, 0, 1);

    // Randomized frames with a random gap pattern.
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < N*N; k++)
        frame[k] = ($urandom_range(0, 2) == 0) ? 20'($urandom) : {8'd0, 12'($urandom)};
      drive_frame(N*N, int'($urandom_range(0, 2)), f[0]);
    end

    // Idle-state samples without go produce nothing.
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1; in_data = 20'($urandom);
      step();
      check("idle_no_valid", {31'd0, out_valid}, 0);
      check("idle_no_done", {31'd0, done}, 0);
    end
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
